// File: rtl/mfp_uart_transmitter_if.sv
// mfp_uart_transmitter_if
//   Byte handshake between the system side and the UART transmitter.
//   A byte moves on a rising clock edge when byte_valid and byte_ready
//   are both high.
//
//   byte_data  [7:0]  byte offered for transmission
//   byte_valid        byte_data is offered this cycle
//   byte_ready        transmitter can take a byte this cycle
//
//   master : producer of bytes (system side)
//   slave  : consumer of bytes (the transmitter)
interface mfp_uart_transmitter_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/mfp_uart_transmitter.sv
// mfp_uart_transmitter
//   UART transmit side of the MIPSfpga+ serial link. Bytes arrive over a
//   valid/ready handshake, are buffered in a small FIFO and are sent as
//   8N1 frames (start, 8 data bits LSB first, stop) on tx.
//
//   Parameters
//     clock_frequency         system clock in Hz
//     baud_rate               line rate in bit/s
//     clock_cycles_in_symbol  cycles per bit (>= 2)
//     fifo_depth              FIFO entries (power of two, >= 2)
//
//   Ports
//     clock    system clock, rising edge
//     reset    asynchronous, active-high reset
//     byte_if  slave side of the byte handshake
//     tx       serial line, idle high, straight from a register
//     busy     a frame is in progress or bytes are waiting
module mfp_uart_transmitter #(
  parameter int clock_frequency        = 50000000,
  parameter int baud_rate              = 115200,
  parameter int clock_cycles_in_symbol = clock_frequency / baud_rate,
  parameter int fifo_depth             = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  mfp_uart_transmitter_if.slave        byte_if,
  output logic                         tx,
  output logic                         busy
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = $clog2(clock_cycles_in_symbol);

  localparam logic [cnt_w-1:0] symbol_last     = cnt_w'(clock_cycles_in_symbol - 1);
  localparam logic [ptr_w:0]   fifo_full_count = (ptr_w + 1)'(fifo_depth);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       fifo_mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [ptr_w:0]   fifo_count;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Readiness looks only at the registered count, so a pop in the same
  // cycle never opens a slot for a push into a full FIFO.
  assign byte_if.byte_ready = (fifo_count != fifo_full_count);
  assign fifo_empty         = (fifo_count == '0);
  assign push               = byte_if.byte_valid & byte_if.byte_ready;

  // NOTE: storage has no reset; the pointers and count define which
  // entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= byte_if.byte_data;
    end
  end

  // NOTE: every register is assigned with <= so all flops sample the
  // pre-edge values together, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (ptr_w + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (ptr_w + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------
  state_t           state,     state_next;
  logic [cnt_w-1:0] bit_cnt,   bit_cnt_next;
  logic [2:0]       bit_idx,   bit_idx_next;
  logic [7:0]       shift,     shift_next;
  logic             tx_q,      tx_next;
  logic             symbol_end;

  assign symbol_end = (bit_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= symbol_last;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      tx_q    <= tx_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    pop          = 1'b0;
    tx_next      = 1'b1;

    // Within a symbol the counter just runs down; it is reloaded below
    // whenever the symbol ends or a new frame is started.
    if (state != ST_IDLE && !symbol_end) begin
      bit_cnt_next = bit_cnt - cnt_w'(1);
    end

    case (state)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop          = 1'b1;
          shift_next   = fifo_mem[rd_ptr];
          bit_cnt_next = symbol_last;
          state_next   = ST_START;
        end
      end

      ST_START: begin
        tx_next = 1'b0;
        if (symbol_end) begin
          bit_cnt_next = symbol_last;
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end

      ST_DATA: begin
        tx_next = shift[0];
        if (symbol_end) begin
          bit_cnt_next = symbol_last;
          shift_next   = shift >> 1;
          if (bit_idx == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end

      ST_STOP: begin
        tx_next = 1'b1;
        if (symbol_end) begin
          bit_cnt_next = symbol_last;
          // Chain straight into the next start bit when a byte is waiting.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr];
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The line level is registered from the current state, so every symbol
  // appears on tx one cycle after the state that owns it.
  assign tx   = tx_q;
  assign busy = (state != ST_IDLE) | (fifo_count != '0);

endmodule

// File: doc/mfp_uart_transmitter.md
# mfp_uart_transmitter

UART transmit side of the MIPSfpga+ serial link: accepts bytes from the system side through a valid/ready handshake, buffers them in a small FIFO, and serializes each as 8N1 (start, 8 data bits LSB first, 1 stop) on `tx` at `baud_rate`. It sits next to the UART receiver and drives the board's serial TX pin.

## Interface
- `clock_frequency`, 50000000: system clock in Hz.
- `baud_rate`, 115200: line rate in bit/s.
- `clock_cycles_in_symbol`, `clock_frequency / baud_rate` (434 by default, integer division): cycles per bit; must be ≥ 2.
- `fifo_depth`, 4: FIFO entries; power of two, ≥ 2.
- `clock`  in  1: system clock; all state is updated on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `byte_data`  in  8: byte to transmit.
- `byte_valid`  in  1: `byte_data` is offered this cycle.
- `byte_ready`  out  1: FIFO can accept a byte (not full); combinational from FIFO count.
- `tx`  out  1: serial line, idle high; driven directly from a register.
- `busy`  out  1: high while a frame is in progress or the FIFO is non-empty.

## Operation
- Push: at a rising edge with `byte_valid & byte_ready`, `byte_data` is written at the write pointer. When full, `byte_valid` is ignored and the byte is not stored; the upstream holds it.
- FIFO: read/write pointers wrap modulo `fifo_depth`. Count is width log2(`fifo_depth`)+1. A push and a pop in the same cycle leave the count unchanged. `byte_ready` depends only on the current count, so a same-cycle pop does not let a push into a full FIFO.
- States:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, load the bit counter with `clock_cycles_in_symbol`-1, and go to START.
  - START: `tx`=0 for one symbol, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for one symbol, then shift right. After bit index 7, go to STOP.
  - STOP: `tx`=1 for one symbol. In its last cycle, if the FIFO is non-empty, pop and go directly to START so frames run back-to-back with no idle gap. Otherwise go to IDLE.
- Bit counter: counts down from `clock_cycles_in_symbol`-1 to 0. The symbol ends in the cycle where the counter is 0; the counter reloads on every state or bit change.
- `busy` = (state != IDLE) | (count != 0).

## Timing
- Reset (asserted, asynchronous):
  - `tx`=1 immediately, even mid-frame.
  - state=IDLE, FIFO emptied (pointers and count 0), shift register 0.
  - `byte_ready`=1, `busy`=0.
  - A partially sent frame is abandoned. The first frame after reset release starts cleanly.
- Latency, idle block with empty FIFO: byte accepted at edge N, popped at edge N+1, `tx` low from edge N+2.
- Symbol lengths: every symbol is exactly `clock_cycles_in_symbol` cycles. A frame is exactly 10×`clock_cycles_in_symbol` cycles.
- Back-to-back frames: the next start bit begins at the edge that ends the previous stop bit, with zero extra cycles between them.
- Popping frees a slot: `byte_ready` rises the cycle after a pop from a full FIFO.
- Pushes are accepted at any point in a frame and do not disturb the frame in progress.

## Test plan
Benches use `clock_frequency`=1000000 and `baud_rate`=100000, giving 10 cycles per symbol. Bit values below are listed in line order.

- Reset, then idle for 50 cycles -> `tx`=1, `byte_ready`=1, `busy`=0 throughout.
- Push 0x55 once -> `tx` low 2 cycles after the accept edge, then 10-cycle levels 0,1,0,1,0,1,0,1,0,1. `busy` falls after exactly 100 cycles of frame.
- Push 0xA3, 0x0F, 0xFF, 0x00 on consecutive cycles -> all four accepted. Four frames run with no gap: bits 1,1,0,0,0,1,0,1 / 1,1,1,1,0,0,0,0 / all 1 / all 0, each framed by start 0 and stop 1. Total 400 cycles.
- Hold `byte_valid`=1 with an incrementing byte while a frame is in progress -> `byte_ready` drops after the FIFO reaches `fifo_depth`. No byte is lost or duplicated: the receiver model decodes an exact sequence.
- Full FIFO with push offered in the same cycle as a pop -> the push is refused that cycle and accepted the next. The count never exceeds `fifo_depth`.
- Assert `reset` mid-DATA of a 0x00 frame -> `tx`=1 at once and the FIFO is empty. After release, push 0x81 -> a clean frame with bits 1,0,0,0,0,0,0,1.
